// File: rtl/apu_reg_writer.sv
// APU register writer: {address, data} byte pairs into a 16 x 8 register file with per-channel change toggles.
// Optional echo of each written byte is built when APU_REG_ECHO_EN is defined.
module apu_reg_writer #(
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [3:0]  ADDR_PAGE      = 4'h4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic [127:0] reg_bus,
  output logic [3:0]   change,
  output logic         frame_err,
  output logic         tx_valid,
  output logic [7:0]   tx_data,
  input  logic         tx_ready
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The expiry edge is the one on which the counter would reach TIMEOUT_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic {ST_ADDR, ST_DATA} state_t;

  state_t                state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic                  bad_q, bad_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [15:0][7:0]      regs_q, regs_d;
  logic [3:0]            change_q, change_d;
  logic                  frame_err_q, frame_err_d;
  logic                  wr_en;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bad_d       = bad_q;
    cnt_d       = cnt_q;
    regs_d      = regs_q;
    change_d    = change_q;
    frame_err_d = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      ST_ADDR: begin
        if (rx_valid) begin
          idx_d   = rx_data[3:0];
          bad_d   = (rx_data[7:4] != ADDR_PAGE);
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          state_d = ST_ADDR;
          if (bad_q) begin
            frame_err_d = 1'b1;
          end else begin
            wr_en                  = 1'b1;
            regs_d[idx_q]          = rx_data;
            change_d[idx_q[3:2]]   = ~change_q[idx_q[3:2]];
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_ADDR;
          frame_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ADDR;
      idx_q       <= '0;
      bad_q       <= 1'b0;
      cnt_q       <= '0;
      regs_q      <= '0;
      change_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bad_q       <= bad_d;
      cnt_q       <= cnt_d;
      regs_q      <= regs_d;
      change_q    <= change_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign reg_bus   = regs_q;
  assign change    = change_q;
  assign frame_err = frame_err_q;

`ifdef APU_REG_ECHO_EN
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;

  // A newer write overwrites a pending echo, so only the latest byte is sent.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
    end
    if (wr_en) begin
      tx_valid_d = 1'b1;
      tx_data_d  = rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
`else
  logic unused_echo;
  assign unused_echo = tx_ready ^ wr_en;
  assign tx_valid    = 1'b0;
  assign tx_data     = 8'h00;
`endif

endmodule
